// File: rtl/arbitration_sub_module.sv
// Bus-ownership front end for a processor with split data/instruction ports.
// Each channel negotiates its own bus and gates traffic so nothing leaks while not owned.

module arb_channel (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic grant_i,
  output logic rq_o,
  output logic conn_o
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_OWN     = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (req_i) state_d = S_REQ;
      S_REQ: begin
        if (!req_i)       state_d = S_IDLE;
        else if (grant_i) state_d = S_OWN;
      end
      // A finished request takes precedence over a simultaneous preemption.
      S_OWN: begin
        if (!req_i)        state_d = S_RELEASE;
        else if (!grant_i) state_d = S_REQ;
      end
      S_RELEASE: if (!grant_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  assign rq_o   = (state_q == S_REQ) || (state_q == S_OWN);
  assign conn_o = (state_q == S_OWN) && grant_i;
endmodule

module arbitration_sub_module (
  input  logic        clk,
  input  logic        reset,
  input  logic        P_DataMem_Read,
  input  logic [3:0]  P_DataMem_Write,
  input  logic [29:0] P_DataMem_Address,
  input  logic [31:0] P_DataMem_Out,
  output logic [31:0] P_DataMem_In,
  output logic        P_DataMem_Ready,
  output logic        Bus_DataMem_Read,
  output logic [3:0]  Bus_DataMem_Write,
  output logic [29:0] Bus_DataMem_Address,
  output logic [31:0] Bus_DataMem_Out,
  input  logic [31:0] Bus_DataMem_In,
  input  logic        Bus_DataMem_Ready,
  output logic        D_Bus_RQ,
  input  logic        D_Bus_GRANT,
  input  logic        P_InstMem_Read,
  input  logic [29:0] P_InstMem_Address,
  output logic [31:0] P_InstMem_In,
  output logic        P_InstMem_Ready,
  output logic        Bus_InstMem_Read,
  output logic [29:0] Bus_InstMem_Address,
  input  logic [31:0] Bus_InstMem_In,
  input  logic        Bus_InstMem_Ready,
  output logic        I_Bus_RQ,
  input  logic        I_Bus_GRANT
);
  // Lane 0 is the data channel, lane 1 the instruction channel.
  logic [1:0] req, gnt, rq, conn;

  assign req = {P_InstMem_Read, (P_DataMem_Read || (P_DataMem_Write != 4'b0))};
  assign gnt = {I_Bus_GRANT, D_Bus_GRANT};

  arb_channel u_ch [1:0] (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req),
    .grant_i (gnt),
    .rq_o    (rq),
    .conn_o  (conn)
  );

  assign D_Bus_RQ = rq[0];
  assign I_Bus_RQ = rq[1];

  assign Bus_DataMem_Read    = conn[0] ? P_DataMem_Read    : 1'b0;
  assign Bus_DataMem_Write   = conn[0] ? P_DataMem_Write   : 4'b0;
  assign Bus_DataMem_Address = conn[0] ? P_DataMem_Address : 30'b0;
  assign Bus_DataMem_Out     = conn[0] ? P_DataMem_Out     : 32'b0;
  assign P_DataMem_In        = conn[0] ? Bus_DataMem_In    : 32'b0;
  assign P_DataMem_Ready     = conn[0] ? Bus_DataMem_Ready : 1'b0;

  assign Bus_InstMem_Read    = conn[1] ? P_InstMem_Read    : 1'b0;
  assign Bus_InstMem_Address = conn[1] ? P_InstMem_Address : 30'b0;
  assign P_InstMem_In        = conn[1] ? Bus_InstMem_In    : 32'b0;
  assign P_InstMem_Ready     = conn[1] ? Bus_InstMem_Ready : 1'b0;
endmodule

// File: tb/tb_arbitration_sub_module.sv
// Directed vector table for arbitration_sub_module plus a hand-written preemption sequence.

module tb_arbitration_sub_module;
  logic        clk = 1'b0;
  logic        reset;
  logic        P_DataMem_Read;
  logic [3:0]  P_DataMem_Write;
  logic [29:0] P_DataMem_Address;
  logic [31:0] P_DataMem_Out;
  logic [31:0] P_DataMem_In;
  logic        P_DataMem_Ready;
  logic        Bus_DataMem_Read;
  logic [3:0]  Bus_DataMem_Write;
  logic [29:0] Bus_DataMem_Address;
  logic [31:0] Bus_DataMem_Out;
  logic [31:0] Bus_DataMem_In;
  logic        Bus_DataMem_Ready;
  logic        D_Bus_RQ;
  logic        D_Bus_GRANT;
  logic        P_InstMem_Read;
  logic [29:0] P_InstMem_Address;
  logic [31:0] P_InstMem_In;
  logic        P_InstMem_Ready;
  logic        Bus_InstMem_Read;
  logic [29:0] Bus_InstMem_Address;
  logic [31:0] Bus_InstMem_In;
  logic        Bus_InstMem_Ready;
  logic        I_Bus_RQ;
  logic        I_Bus_GRANT;

  arbitration_sub_module dut (
    .clk(clk), .reset(reset),
    .P_DataMem_Read(P_DataMem_Read), .P_DataMem_Write(P_DataMem_Write),
    .P_DataMem_Address(P_DataMem_Address), .P_DataMem_Out(P_DataMem_Out),
    .P_DataMem_In(P_DataMem_In), .P_DataMem_Ready(P_DataMem_Ready),
    .Bus_DataMem_Read(Bus_DataMem_Read), .Bus_DataMem_Write(Bus_DataMem_Write),
    .Bus_DataMem_Address(Bus_DataMem_Address), .Bus_DataMem_Out(Bus_DataMem_Out),
    .Bus_DataMem_In(Bus_DataMem_In), .Bus_DataMem_Ready(Bus_DataMem_Ready),
    .D_Bus_RQ(D_Bus_RQ), .D_Bus_GRANT(D_Bus_GRANT),
    .P_InstMem_Read(P_InstMem_Read), .P_InstMem_Address(P_InstMem_Address),
    .P_InstMem_In(P_InstMem_In), .P_InstMem_Ready(P_InstMem_Ready),
    .Bus_InstMem_Read(Bus_InstMem_Read), .Bus_InstMem_Address(Bus_InstMem_Address),
    .Bus_InstMem_In(Bus_InstMem_In), .Bus_InstMem_Ready(Bus_InstMem_Ready),
    .I_Bus_RQ(I_Bus_RQ), .I_Bus_GRANT(I_Bus_GRANT)
  );

  always #5 clk = ~clk;

  // Inputs applied for one cycle and the outputs expected during that cycle (before its edge).
  typedef struct {
    logic [31:0] rst, drd, dwr, daddr, dout, dbin, dbrdy, dgnt;
    logic [31:0] ird, iaddr, ibin, ibrdy, ignt;
    logic [31:0] e_drq, e_drd, e_dwr, e_daddr, e_dout, e_din, e_drdy;
    logic [31:0] e_irq, e_ird, e_iaddr, e_iin, e_irdy;
  } vec_t;

  localparam int NV = 29;
  vec_t tv [NV];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input vec_t v);
    chk("D_Bus_RQ",            idx, 32'(D_Bus_RQ),            v.e_drq);
    chk("Bus_DataMem_Read",    idx, 32'(Bus_DataMem_Read),    v.e_drd);
    chk("Bus_DataMem_Write",   idx, 32'(Bus_DataMem_Write),   v.e_dwr);
    chk("Bus_DataMem_Address", idx, 32'(Bus_DataMem_Address), v.e_daddr);
    chk("Bus_DataMem_Out",     idx, Bus_DataMem_Out,          v.e_dout);
    chk("P_DataMem_In",        idx, P_DataMem_In,             v.e_din);
    chk("P_DataMem_Ready",     idx, 32'(P_DataMem_Ready),     v.e_drdy);
    chk("I_Bus_RQ",            idx, 32'(I_Bus_RQ),            v.e_irq);
    chk("Bus_InstMem_Read",    idx, 32'(Bus_InstMem_Read),    v.e_ird);
    chk("Bus_InstMem_Address", idx, 32'(Bus_InstMem_Address), v.e_iaddr);
    chk("P_InstMem_In",        idx, P_InstMem_In,             v.e_iin);
    chk("P_InstMem_Ready",     idx, 32'(P_InstMem_Ready),     v.e_irdy);
  endtask

  task automatic drive(input vec_t v);
    reset             = v.rst[0];
    P_DataMem_Read    = v.drd[0];
    P_DataMem_Write   = v.dwr[3:0];
    P_DataMem_Address = v.daddr[29:0];
    P_DataMem_Out     = v.dout;
    Bus_DataMem_In    = v.dbin;
    Bus_DataMem_Ready = v.dbrdy[0];
    D_Bus_GRANT       = v.dgnt[0];
    P_InstMem_Read    = v.ird[0];
    P_InstMem_Address = v.iaddr[29:0];
    Bus_InstMem_In    = v.ibin;
    Bus_InstMem_Ready = v.ibrdy[0];
    I_Bus_GRANT       = v.ignt[0];
  endtask

  initial begin
    //         rst drd dwr daddr dout dbin dbrdy dgnt ird iaddr ibin ibrdy ignt | drq drd dwr daddr dout din drdy irq ird iaddr iin irdy
    tv[0]  = '{1, 0, 0,   0, 0,    0,     0, 0,  0, 0, 0,     0, 0,  0, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};
    tv[1]  = '{0, 1, 0,   5, 0,    'hFF,  1, 0,  0, 0, 0,     0, 0,  0, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};
    tv[2]  = '{0, 1, 0,   5, 0,    'hFF,  1, 0,  0, 0, 0,     0, 0,  1, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};
    tv[3]  = '{0, 1, 0,   5, 0,    'h11,  1, 1,  0, 0, 0,     0, 0,  1, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};
    tv[4]  = '{0, 1, 0,   5, 0,    'h11,  1, 1,  0, 0, 0,     0, 0,  1, 1, 0,   5, 0,    'h11,  1,  0, 0, 0, 0,     0};
    tv[5]  = '{0, 1, 0,   5, 0,    'h11,  1, 0,  0, 0, 0,     0, 0,  1, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};
    tv[6]  = '{0, 1, 0,   5, 0,    'h11,  1, 0,  0, 0, 0,     0, 0,  1, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};
    tv[7]  = '{0, 1, 0,   5, 0,    'h22,  1, 1,  0, 0, 0,     0, 0,  1, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};
    tv[8]  = '{0, 1, 0,   5, 0,    'h22,  1, 1,  0, 0, 0,     0, 0,  1, 1, 0,   5, 0,    'h22,  1,  0, 0, 0, 0,     0};
    tv[9]  = '{0, 0, 'hF, 5, 'hF,  0,     1, 1,  0, 0, 0,     0, 0,  1, 0, 'hF, 5, 'hF,  0,     1,  0, 0, 0, 0,     0};
    tv[10] = '{0, 0, 0,   0, 0,    0,     0, 1,  0, 0, 0,     0, 0,  1, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};
    tv[11] = '{0, 0, 0,   0, 0,    'h99,  1, 1,  0, 0, 0,     0, 0,  0, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};
    tv[12] = '{0, 0, 0,   0, 0,    0,     0, 0,  0, 0, 0,     0, 0,  0, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};
    tv[13] = '{0, 0, 0,   0, 0,    0,     0, 0,  0, 0, 0,     0, 0,  0, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};
    tv[14] = '{0, 1, 0,   3, 0,    0,     0, 0,  0, 0, 0,     0, 0,  0, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};
    tv[15] = '{0, 1, 0,   3, 0,    0,     0, 1,  0, 0, 0,     0, 0,  1, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};
    tv[16] = '{0, 0, 0,   3, 0,    0,     0, 0,  0, 0, 0,     0, 0,  1, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};
    tv[17] = '{0, 0, 0,   0, 0,    0,     0, 0,  0, 0, 0,     0, 0,  0, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};
    tv[18] = '{0, 0, 0,   0, 0,    0,     0, 0,  0, 0, 0,     0, 0,  0, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};
    tv[19] = '{0, 1, 0,   7, 0,    0,     0, 0,  1, 4, 0,     0, 0,  0, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};
    tv[20] = '{0, 1, 0,   7, 0,    'h33,  1, 1,  1, 4, 'h44,  1, 1,  1, 0, 0,   0, 0,    0,     0,  1, 0, 0, 0,     0};
    tv[21] = '{0, 1, 0,   7, 0,    'h33,  1, 1,  1, 4, 'h44,  1, 1,  1, 1, 0,   7, 0,    'h33,  1,  1, 1, 4, 'h44,  1};
    tv[22] = '{1, 1, 0,   7, 0,    'h33,  1, 1,  1, 4, 'h44,  1, 1,  1, 1, 0,   7, 0,    'h33,  1,  1, 1, 4, 'h44,  1};
    tv[23] = '{0, 1, 0,   7, 0,    'h33,  1, 1,  1, 4, 'h44,  1, 1,  0, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};
    tv[24] = '{0, 1, 0,   7, 0,    'h33,  1, 1,  1, 4, 'h44,  1, 1,  1, 0, 0,   0, 0,    0,     0,  1, 0, 0, 0,     0};
    tv[25] = '{1, 0, 0,   0, 0,    0,     0, 0,  0, 0, 0,     0, 0,  1, 0, 0,   0, 0,    0,     0,  1, 0, 0, 0,     0};
    tv[26] = '{0, 0, 0,   0, 0,    0,     0, 0,  1, 8, 0,     0, 0,  0, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};
    tv[27] = '{0, 0, 0,   0, 0,    0,     0, 0,  0, 8, 0,     0, 0,  0, 0, 0,   0, 0,    0,     0,  1, 0, 0, 0,     0};
    tv[28] = '{0, 0, 0,   0, 0,    0,     0, 0,  0, 0, 0,     0, 0,  0, 0, 0,   0, 0,    0,     0,  0, 0, 0, 0,     0};

    drive(tv[0]);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(tv[i]);
      #2;
      check_all(i, tv[i]);
      @(posedge clk); #1;
    end

    // Preemption observed mid-cycle: the bus must drop with the grant, not a clock later.
    P_DataMem_Read = 1'b1; P_DataMem_Address = 30'd9;
    Bus_DataMem_In = 32'h55; Bus_DataMem_Ready = 1'b1; D_Bus_GRANT = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("hs_own_in",    100, P_DataMem_In, 32'h55);
    chk("hs_own_addr",  100, 32'(Bus_DataMem_Address), 32'd9);
    D_Bus_GRANT = 1'b0;
    #1;
    chk("hs_pre_in",    101, P_DataMem_In, 32'h0);
    chk("hs_pre_rdy",   101, 32'(P_DataMem_Ready), 32'h0);
    chk("hs_pre_addr",  101, 32'(Bus_DataMem_Address), 32'h0);
    chk("hs_pre_rq",    101, 32'(D_Bus_RQ), 32'h1);
    @(posedge clk); #1;
    chk("hs_req_rq",    102, 32'(D_Bus_RQ), 32'h1);
    D_Bus_GRANT = 1'b1;
    #1;
    chk("hs_regrant0",  103, 32'(Bus_DataMem_Read), 32'h0);
    @(posedge clk); #1;
    chk("hs_resume_rd", 104, 32'(Bus_DataMem_Read), 32'h1);
    chk("hs_resume_in", 104, P_DataMem_In, 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
